// File: rtl/procyon_biu_pkg.sv
// Shared types and Wishbone cycle-type encodings for the Procyon bus interface unit.
package procyon_biu_pkg;

  localparam int BIU_STATE_WIDTH = 2;

  typedef enum logic [BIU_STATE_WIDTH-1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } biu_state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;

  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/procyon_biu_wb.sv
// BIU responder: turns one cache-line read/write request into a Wishbone B4
// registered-feedback incrementing burst and reports completion to the arbiter.
module procyon_biu_wb
  import procyon_biu_pkg::*;
#(
  parameter  int OPTN_ADDR_WIDTH    = 32,
  parameter  int OPTN_DC_LINE_SIZE  = 32,
  parameter  int OPTN_WB_DATA_WIDTH = 16,
  localparam int DC_LINE_WIDTH      = OPTN_DC_LINE_SIZE * 8,
  localparam int WB_WORD_SIZE       = OPTN_WB_DATA_WIDTH / 8,
  localparam int WB_BEATS           = DC_LINE_WIDTH / OPTN_WB_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          n_rst,

  input  logic                          i_biu_en,
  input  logic                          i_biu_we,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_biu_addr,
  input  logic [DC_LINE_WIDTH-1:0]      i_biu_data,
  output logic                          o_biu_done,
  output logic                          o_biu_busy,
  output logic [DC_LINE_WIDTH-1:0]      o_biu_data,

  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  output logic                          o_wb_we,
  output logic [2:0]                    o_wb_cti,
  output logic [1:0]                    o_wb_bte,
  output logic [WB_WORD_SIZE-1:0]       o_wb_sel,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_wb_addr,
  output logic [OPTN_WB_DATA_WIDTH-1:0] o_wb_data,
  input  logic                          i_wb_ack,
  input  logic [OPTN_WB_DATA_WIDTH-1:0] i_wb_data
);

  localparam int BEAT_W     = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1;
  localparam int WORD_SHIFT = $clog2(WB_WORD_SIZE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WB_BEATS - 1);

  biu_state_t                   state;
  biu_state_t                   state_nxt;
  logic [BEAT_W-1:0]            beat;
  logic [BEAT_W-1:0]            beat_nxt;
  logic [OPTN_ADDR_WIDTH-1:0]   base_addr;
  logic [OPTN_ADDR_WIDTH-1:0]   line_base;
  logic [DC_LINE_WIDTH-1:0]     wr_line;
  logic [DC_LINE_WIDTH-1:0]     rd_buf;
  logic [DC_LINE_WIDTH-1:0]     rd_merge;
  logic                         accept;
  logic                         beat_ack;
  logic                         last_ack;

  assign line_base = i_biu_addr & ~OPTN_ADDR_WIDTH'(OPTN_DC_LINE_SIZE - 1);
  assign accept    = (state == IDLE) && i_biu_en;
  // Acks outside an active strobe never advance the burst.
  assign beat_ack  = (state == BUSY) && o_wb_stb && i_wb_ack;
  assign last_ack  = beat_ack && (beat == LAST_BEAT);
  assign beat_nxt  = (beat == LAST_BEAT) ? '0 : beat + 1'b1;
  assign o_wb_bte  = WB_BTE_LINEAR;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_biu_en)  state_nxt = BUSY;
      BUSY:    if (last_ack)  state_nxt = DONE;
      DONE:                   state_nxt = RELEASE;
      RELEASE: if (!i_biu_en) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Read line with the beat currently being acknowledged merged in.
  always_comb begin
    rd_merge = rd_buf;
    rd_merge[int'(beat)*OPTN_WB_DATA_WIDTH +: OPTN_WB_DATA_WIDTH] = i_wb_data;
  end

  // NOTE: reset is synchronous here, so it only appears inside the clocked branch, never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_cti   <= WB_CTI_CLASSIC;
      o_biu_done <= 1'b0;
      o_biu_busy <= 1'b0;
      beat       <= '0;
    end else begin
      o_biu_done <= last_ack;
      o_biu_busy <= (state_nxt != IDLE);
      if (accept) begin
        o_wb_cyc <= 1'b1;
        o_wb_stb <= 1'b1;
        o_wb_we  <= i_biu_we;
        o_wb_cti <= (WB_BEATS == 1) ? WB_CTI_EOB : WB_CTI_INCR;
        beat     <= '0;
      end else if (last_ack) begin
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        o_wb_we  <= 1'b0;
        o_wb_cti <= WB_CTI_CLASSIC;
        beat     <= beat_nxt;
      end else if (beat_ack) begin
        o_wb_cti <= (beat_nxt == LAST_BEAT) ? WB_CTI_EOB : WB_CTI_INCR;
        beat     <= beat_nxt;
      end
    end
  end

  // NOTE: the wide line buffers and beat payload carry no reset; they are only observed when qualified by stb or done.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_addr <= line_base;
      wr_line   <= i_biu_data;
      o_wb_addr <= line_base;
      o_wb_data <= i_biu_data[OPTN_WB_DATA_WIDTH-1:0];
      o_wb_sel  <= '1;
    end else if (beat_ack) begin
      o_wb_addr <= base_addr + (OPTN_ADDR_WIDTH'(beat_nxt) << WORD_SHIFT);
      o_wb_data <= wr_line[int'(beat_nxt)*OPTN_WB_DATA_WIDTH +: OPTN_WB_DATA_WIDTH];
      rd_buf    <= rd_merge;
      if (last_ack && !o_wb_we) o_biu_data <= rd_merge;
    end
  end

endmodule

// File: tb/tb_procyon_biu_wb.sv
// Self-checking bench for procyon_biu_wb: a behavioural Wishbone slave records every
// accepted beat and each scenario compares it against the expected line-burst behaviour.
module tb_procyon_biu_wb;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int DW = 16;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration DUT
  logic            biu_en = 1'b0, biu_we = 1'b0;
  logic [AW-1:0]   biu_addr = '0;
  logic [LW-1:0]   biu_wdata = '0;
  logic            biu_done, biu_busy;
  logic [LW-1:0]   biu_rdata;
  logic            wb_cyc, wb_stb, wb_we;
  logic [2:0]      wb_cti;
  logic [1:0]      wb_bte;
  logic [1:0]      wb_sel;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_wdata;
  logic            wb_ack = 1'b0;
  logic [DW-1:0]   wb_rdata = '0;

  procyon_biu_wb dut (
    .clk(clk), .n_rst(n_rst),
    .i_biu_en(biu_en), .i_biu_we(biu_we), .i_biu_addr(biu_addr), .i_biu_data(biu_wdata),
    .o_biu_done(biu_done), .o_biu_busy(biu_busy), .o_biu_data(biu_rdata),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_cti(wb_cti),
    .o_wb_bte(wb_bte), .o_wb_sel(wb_sel), .o_wb_addr(wb_addr), .o_wb_data(wb_wdata),
    .i_wb_ack(wb_ack), .i_wb_data(wb_rdata)
  );

  // Single-beat configuration (bus as wide as the line)
  logic            w1_en = 1'b0, w1_we = 1'b0;
  logic [AW-1:0]   w1_addr = '0;
  logic [LW-1:0]   w1_wdata = '0;
  logic            w1_done, w1_busy;
  logic [LW-1:0]   w1_rdata;
  logic            w1_cyc, w1_stb, w1_wwe;
  logic [2:0]      w1_cti;
  logic [1:0]      w1_bte;
  logic [31:0]     w1_sel;
  logic [AW-1:0]   w1_wb_addr;
  logic [LW-1:0]   w1_wb_wdata;
  logic            w1_ack = 1'b0;
  logic [LW-1:0]   w1_wb_rdata = '0;

  procyon_biu_wb #(.OPTN_WB_DATA_WIDTH(256)) dut_w1 (
    .clk(clk), .n_rst(n_rst),
    .i_biu_en(w1_en), .i_biu_we(w1_we), .i_biu_addr(w1_addr), .i_biu_data(w1_wdata),
    .o_biu_done(w1_done), .o_biu_busy(w1_busy), .o_biu_data(w1_rdata),
    .o_wb_cyc(w1_cyc), .o_wb_stb(w1_stb), .o_wb_we(w1_wwe), .o_wb_cti(w1_cti),
    .o_wb_bte(w1_bte), .o_wb_sel(w1_sel), .o_wb_addr(w1_wb_addr), .o_wb_data(w1_wb_wdata),
    .i_wb_ack(w1_ack), .i_wb_data(w1_wb_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural slave: line memory of NB words, ack policy per mode
  // (0 = zero-wait, 1 = ack every other strobe cycle, 2 = random incl. stray acks).
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [1:0]    sel;
  } beat_t;

  beat_t         beats[$];
  logic [DW-1:0] rd_pattern[NB];
  int            ack_mode = 0;
  bit            toggle = 1'b0;
  bit            was_stall = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  int            stall_viol = 0;
  int            done_count = 0;
  bit            hold_en = 1'b0;
  logic [LW-1:0] hold_val;
  int            hold_viol = 0;

  always @(negedge clk) begin : slave
    logic allow;
    allow = 1'b1;
    if (ack_mode == 1) allow = toggle;
    else if (ack_mode == 2) allow = 1'($urandom_range(0, 1));
    toggle = wb_stb ? ~toggle : 1'b0;
    if (was_stall && wb_stb && (wb_addr !== held_addr || wb_wdata !== held_data)) stall_viol++;
    was_stall = wb_stb && !allow;
    held_addr = wb_addr;
    held_data = wb_wdata;
    wb_ack    = allow && (wb_stb || ack_mode == 2);
    wb_rdata  = rd_pattern[wb_addr[4:1]];
    if (wb_stb && wb_ack)
      beats.push_back('{addr: wb_addr, we: wb_we, data: wb_wdata, cti: wb_cti, bte: wb_bte, sel: wb_sel});
  end

  always @(negedge clk) begin
    if (biu_done) done_count++;
    if (hold_en && biu_rdata !== hold_val) hold_viol++;
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LW-1:0] pattern_line();
    logic [LW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*DW +: DW] = rd_pattern[k];
    return l;
  endfunction

  task automatic start_req(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] line);
    @(negedge clk);
    biu_en = 1'b1; biu_we = we; biu_addr = addr; biu_wdata = line;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (biu_done) begin ok = 1'b1; break; end
    end
  endtask

  // One full line transaction, scored against the expected burst.
  task automatic run_line(input string name, input logic we, input logic [AW-1:0] addr,
                          input logic [LW-1:0] line, input int mode, input int exp_cyc);
    logic [AW-1:0] base;
    logic [LW-1:0] exp_line;
    int cyc, d0;
    bit ok;
    base = addr & ~32'h1F;
    exp_line = pattern_line();
    beats.delete();
    ack_mode = mode;
    d0 = done_count;
    start_req(we, addr, line);
    wait_done(400, cyc, ok);
    biu_en = 1'b0; biu_we = 1'($urandom); biu_addr = $urandom; biu_wdata = rand_line();
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s done_timeout: no done within 400 cycles", name); end
    if (ok && exp_cyc >= 0) begin
      vectors++;
      if (cyc !== exp_cyc) begin miscompares++; $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_cyc); end
    end
    if (ok && !we) begin
      vectors++;
      if (biu_rdata !== exp_line) begin miscompares++; $display("FAIL %s read_line: got %h expected %h", name, biu_rdata, exp_line); end
    end
    vectors++;
    if (beats.size() != NB) begin miscompares++; $display("FAIL %s beat_count: got %0d expected %0d", name, beats.size(), NB); end
    for (int k = 0; k < NB && k < beats.size(); k++) begin
      vectors++;
      if (beats[k].addr !== base + AW'(2*k) || beats[k].we !== we ||
          beats[k].cti !== ((k == NB-1) ? 3'b111 : 3'b010) || beats[k].bte !== 2'b00 || beats[k].sel !== 2'b11) begin
        miscompares++;
        $display("FAIL %s beat%0d_ctrl: got addr=%h we=%b cti=%b bte=%b sel=%b expected addr=%h we=%b cti=%b bte=00 sel=11",
                 name, k, beats[k].addr, beats[k].we, beats[k].cti, beats[k].bte, beats[k].sel,
                 base + AW'(2*k), we, (k == NB-1) ? 3'b111 : 3'b010);
      end
      if (we) begin
        vectors++;
        if (beats[k].data !== {line[16*k+8 +: 8], line[16*k +: 8]}) begin
          miscompares++;
          $display("FAIL %s beat%0d_wdata: got %h expected %h", name, k, beats[k].data, {line[16*k+8 +: 8], line[16*k +: 8]});
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (biu_done !== 1'b0 || done_count != d0 + 1) begin
      miscompares++;
      $display("FAIL %s done_pulse: done=%b pulses=%0d expected done=0 pulses=1", name, biu_done, done_count - d0);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({wb_cyc, wb_stb, wb_we, wb_cti, biu_done, biu_busy} !== 8'b0 ||
        {w1_cyc, w1_stb, w1_wwe, w1_cti, w1_done, w1_busy} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_state: got cyc=%b stb=%b we=%b cti=%b done=%b busy=%b (w1 cyc=%b busy=%b) expected all zero",
               wb_cyc, wb_stb, wb_we, wb_cti, biu_done, biu_busy, w1_cyc, w1_busy);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_read_basic();
    for (int k = 0; k < NB; k++) rd_pattern[k] = 16'h0A00 + 16'(k);
    run_line("read_basic", 1'b0, 32'h1000_0004, rand_line(), 0, 17);
  endtask

  task automatic test_write_stall();
    logic [LW-1:0] line;
    for (int i = 0; i < 32; i++) line[i*8 +: 8] = 8'(i);
    stall_viol = 0;
    run_line("write_stall", 1'b1, 32'h2000_0040, line, 1, -1);
    vectors++;
    if (stall_viol != 0) begin miscompares++; $display("FAIL write_stall hold: got %0d changes during stalls expected 0", stall_viol); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < NB; k++) rd_pattern[k] = 16'($urandom);
      stall_viol = 0;
      run_line($sformatf("random%0d", t), 1'($urandom), $urandom, rand_line(), 2, -1);
      vectors++;
      if (stall_viol != 0) begin miscompares++; $display("FAIL random%0d hold: got %0d expected 0", t, stall_viol); end
    end
  endtask

  task automatic test_handshake();
    int cyc, d0;
    bit ok;
    for (int k = 0; k < NB; k++) rd_pattern[k] = 16'($urandom);
    beats.delete();
    ack_mode = 0;
    d0 = done_count;
    start_req(1'b0, 32'h3000_0000, rand_line());
    wait_done(400, cyc, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL handshake done_timeout: no done within 400 cycles"); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (wb_cyc !== 1'b0 || biu_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL handshake lag%0d: got cyc=%b busy=%b expected cyc=0 busy=1", i, wb_cyc, biu_busy);
      end
    end
    biu_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (biu_busy !== 1'b0 || beats.size() != NB || done_count != d0 + 1) begin
      miscompares++;
      $display("FAIL handshake release: got busy=%b beats=%0d pulses=%0d expected busy=0 beats=16 pulses=1",
               biu_busy, beats.size(), done_count - d0);
    end
    biu_en = 1'b1; biu_we = 1'b0; biu_addr = 32'h3000_0123;
    @(negedge clk);
    vectors++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_addr !== 32'h3000_0120) begin
      miscompares++;
      $display("FAIL handshake restart: got cyc=%b stb=%b addr=%h expected cyc=1 stb=1 addr=30000120", wb_cyc, wb_stb, wb_addr);
    end
    wait_done(400, cyc, ok);
    biu_en = 1'b0;
    vectors++;
    if (!ok || biu_rdata !== pattern_line()) begin
      miscompares++;
      $display("FAIL handshake second: got done=%b line=%h expected done=1 line=%h", ok, biu_rdata, pattern_line());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d0;
    bit found;
    for (int k = 0; k < NB; k++) rd_pattern[k] = 16'($urandom);
    ack_mode = 0;
    d0 = done_count;
    found = 1'b0;
    start_req(1'b0, 32'h4000_0010, rand_line());
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wb_stb && wb_addr == 32'h4000_000E) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL reset_mid beat7: beat 7 not presented within 40 cycles"); end
    n_rst = 1'b0; biu_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || biu_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid abort: got cyc=%b stb=%b busy=%b expected 0 0 0", wb_cyc, wb_stb, biu_busy);
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (done_count != d0) begin miscompares++; $display("FAIL reset_mid no_done: got %0d pulses expected 0", done_count - d0); end
    for (int k = 0; k < NB; k++) rd_pattern[k] = 16'($urandom);
    run_line("reset_mid_after", 1'b0, 32'h4000_0008, rand_line(), 0, 17);
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] line_a;
    logic [AW-1:0] addr_a;
    addr_a = $urandom;
    for (int k = 0; k < NB; k++) rd_pattern[k] = 16'($urandom);
    line_a = pattern_line();
    run_line("b2b_read", 1'b0, addr_a, rand_line(), 2, -1);
    for (int k = 0; k < NB; k++) rd_pattern[k] = 16'($urandom);
    hold_val = line_a;
    hold_viol = 0;
    hold_en = 1'b1;
    run_line("b2b_write", 1'b1, addr_a + 32'h20 * $urandom_range(1, 100), rand_line(), 0, 17);
    hold_en = 1'b0;
    vectors++;
    if (hold_viol != 0) begin miscompares++; $display("FAIL b2b hold: got %0d cycles with changed read line expected 0", hold_viol); end
  endtask

  task automatic test_single_beat();
    logic [LW-1:0] rdat, wline;
    logic [AW-1:0] a;
    for (int t = 0; t < 2; t++) begin
      rdat = rand_line(); wline = rand_line(); a = $urandom;
      @(negedge clk);
      w1_en = 1'b1; w1_we = 1'(t); w1_addr = a; w1_wdata = wline;
      @(negedge clk);
      vectors++;
      if (w1_cyc !== 1'b1 || w1_stb !== 1'b1 || w1_cti !== 3'b111 || w1_wwe !== 1'(t) ||
          w1_wb_addr !== (a & ~32'h1F) || w1_sel !== 32'hFFFF_FFFF) begin
        miscompares++;
        $display("FAIL single%0d beat: got cyc=%b stb=%b cti=%b we=%b addr=%h sel=%h expected 1 1 111 %0d %h ffffffff",
                 t, w1_cyc, w1_stb, w1_cti, w1_wwe, w1_wb_addr, w1_sel, t, a & ~32'h1F);
      end
      if (t == 1) begin
        vectors++;
        if (w1_wb_wdata !== wline) begin miscompares++; $display("FAIL single1 wdata: got %h expected %h", w1_wb_wdata, wline); end
      end
      w1_ack = 1'b1; w1_wb_rdata = rdat;
      @(negedge clk);
      w1_ack = 1'b0; w1_en = 1'b0;
      vectors++;
      if (w1_done !== 1'b1 || w1_cyc !== 1'b0) begin
        miscompares++;
        $display("FAIL single%0d done: got done=%b cyc=%b at cycle 2 expected done=1 cyc=0", t, w1_done, w1_cyc);
      end
      if (t == 0) begin
        vectors++;
        if (w1_rdata !== rdat) begin miscompares++; $display("FAIL single0 rdata: got %h expected %h", w1_rdata, rdat); end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    for (int k = 0; k < NB; k++) rd_pattern[k] = '0;
    test_reset();
    test_read_basic();
    test_write_stall();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_single_beat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
